fetch_decode_unit: RTL and testbench
====================================

// Module: fetch_decode_unit
// PURPOSE
//  Instruction fetch/decode stage in front of the 16x8 program/data RAM. Holds PC/AR/IR,
//  drives the RAM read port, resolves the indirect bit to an effective address and hands
//  one decoded instruction at a time to the execute stage over a valid/ready handshake.
//  Instruction format: [7]=I, [6:4]=opcode, [3:0]=address. Opcode 7 = register-ref (I=0) or I/O (I=1).
// PARAMETERS
//  ADDR_W    4   RAM address width; PC, AR and the address field are ADDR_W bits
//  DATA_W    8   RAM word width; must equal ADDR_W+4
//  RESET_PC  0   PC value loaded at reset
// PORTS
//  clk         in   1       single clock; all state changes on posedge
//  rst         in   1       asynchronous, active-high reset
//  mem_read    out  1       RAM read strobe; high only in FETCH and INDIR
//  mem_addr    out  ADDR_W  RAM address (PC in FETCH, IR[3:0] in INDIR, else 0)
//  mem_rdata   in   DATA_W  RAM data_out; combinational, valid same cycle as mem_read
//  pc_load     in   1       redirect request from execute (branch/skip)
//  pc_value    in   ADDR_W  new PC when pc_load=1
//  halt        in   1       stop fetching at next instruction boundary
//  run         in   1       leave HALT
//  dec_valid   out  1       decoded instruction available
//  dec_ready   in   1       execute accepts when dec_valid&dec_ready
//  dec_ir      out  DATA_W  raw instruction word
//  dec_op      out  3       opcode IR[6:4]
//  dec_i       out  1       indirect bit IR[7]
//  dec_ea      out  ADDR_W  effective address (after indirection for memory-ref)
//  dec_is_mem / dec_is_reg / dec_is_io  out 1 each  one-hot class flags
//  pc          out  ADDR_W  current PC (address of next fetch)
//  halted      out  1       high in HALT state
// BEHAVIOUR
//  Reset: state=ADDR, PC=RESET_PC, IR=0, AR=0; all dec_* outputs, mem_read, halted = 0.
//  States: ADDR -> FETCH -> DECODE -> (INDIR) -> ISSUE -> ADDR; HALT.
//   ADDR:   if halt -> HALT else -> FETCH.
//   FETCH:  mem_read=1, mem_addr=PC; IR<=mem_rdata; PC<=PC+1 (mod 2^ADDR_W, 15->0) -> DECODE.
//   DECODE: AR<=IR[3:0]; if IR[6:4]!=7 && IR[7] -> INDIR else -> ISSUE.
//   INDIR:  mem_read=1, mem_addr=IR[3:0]; AR<=mem_rdata[ADDR_W-1:0] -> ISSUE.
//   ISSUE:  dec_valid=1; dec_* registered and stable until accepted; on dec_ready -> ADDR.
//   HALT:   no memory access; run -> ADDR; halt ignored while already halted.
//  Class: op!=7 -> mem; op==7&&!I -> reg; op==7&&I -> io. Exactly one flag set in ISSUE, all 0 otherwise.
//  Latency (dec_ready=1): direct 3 cycles ADDR->dec_valid; indirect 4; throughput 1 instr / 4 (5) cycles.
//  pc_load (any state except HALT): PC<=pc_value, in-flight instruction squashed, next state ADDR,
//   dec_valid low next cycle; pc_load wins over FETCH increment and over a same-cycle accept.
//   In HALT, pc_load updates PC, state stays HALT.
//  Backpressure: dec_ready low holds ISSUE indefinitely; no RAM access, PC unchanged.
//  Reset mid-operation: immediate return to reset values; no partial IR retained.
//  mem_read low in all other states so execute may own the RAM port there.
// STRUCTURE
//  Shared package: opcode localparams (AND=0, ADD=1, LDA=2, STA=3, BUN=4, BSA=5, ISZ=6, REGIO=7),
//   field positions I_BIT/OP_MSB/OP_LSB, state encoding.
//  One sub-module natural: instr_classifier (combinational IR -> op/i/is_mem/is_reg/is_io).
// TESTING
//  RAM preset ram[0..3]=0C,91,26,76, ram[10]=1B; all use dec_ready=1 unless stated.
//  T1 reset release, PC=0 -> cycle 3 dec_valid=1, dec_op=0, dec_i=0, dec_ea=C, dec_is_mem=1, PC=1.
//  T2 fetch 0x91 (I=1, op=1) -> INDIR reads ram[1]=0x91, dec_ea=1 at cycle 4; 0x26 -> op=2, ea=6.
//  T3 fetch 0x76 -> no INDIR, dec_is_reg=1, dec_ea=6; 0xF0-type word with op=7,I=1 -> dec_is_io=1.
//  T4 pc_load=1, pc_value=A during DECODE -> dec_valid stays 0, next fetch addr A, dec_ir=1B.
//  T5 dec_ready low 5 cycles in ISSUE -> dec_* stable, mem_read=0, PC unchanged; accept -> ADDR.
//  T6 PC=F fetch -> PC wraps to 0; halt in ADDR -> halted=1, no mem_read; run -> resumes at PC.

Source files
------------

// File: rtl/fetch_decode_unit_pkg.sv
// Shared definitions for the fetch/decode stage: opcodes, instruction field
// positions and the sequencer state encoding.
package fetch_decode_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_ADD   = 3'd1,
        OP_LDA   = 3'd2,
        OP_STA   = 3'd3,
        OP_BUN   = 3'd4,
        OP_BSA   = 3'd5,
        OP_ISZ   = 3'd6,
        OP_REGIO = 3'd7
    } opcode_t;

    localparam int I_BIT  = 7;
    localparam int OP_MSB = 6;
    localparam int OP_LSB = 4;

    typedef enum logic [2:0] {
        S_ADDR,
        S_FETCH,
        S_DECODE,
        S_INDIR,
        S_ISSUE,
        S_HALT
    } state_t;

endpackage

// File: rtl/fetch_decode_unit_if.sv
// RAM read port and decoded-instruction handshake between fetch/decode and execute.
interface fetch_decode_unit_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    logic              dec_valid;
    logic              dec_ready;
    logic [DATA_W-1:0] dec_ir;
    logic [2:0]        dec_op;
    logic              dec_i;
    logic [ADDR_W-1:0] dec_ea;
    logic              dec_is_mem;
    logic              dec_is_reg;
    logic              dec_is_io;

    modport master (
        output mem_read, mem_addr,
        input  mem_rdata,
        output dec_valid, dec_ir, dec_op, dec_i, dec_ea,
        output dec_is_mem, dec_is_reg, dec_is_io,
        input  dec_ready
    );

    modport slave (
        input  mem_read, mem_addr,
        output mem_rdata,
        input  dec_valid, dec_ir, dec_op, dec_i, dec_ea,
        input  dec_is_mem, dec_is_reg, dec_is_io,
        output dec_ready
    );

endinterface

// File: rtl/fetch_decode_unit_instr_classifier.sv
// Combinational split of an instruction word into fields and a one-hot class.
module fetch_decode_unit_instr_classifier
    import fetch_decode_unit_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] ir,
    output logic [2:0]        op,
    output logic              i,
    output logic [ADDR_W-1:0] addr,
    output logic              is_mem,
    output logic              is_reg,
    output logic              is_io,
    output logic              need_indir
);

    assign op   = ir[OP_MSB:OP_LSB];
    assign i    = ir[I_BIT];
    assign addr = ir[ADDR_W-1:0];

    // Opcode 7 never dereferences memory, so its I bit selects reg vs I/O instead.
    assign is_mem     = (op != OP_REGIO);
    assign is_reg     = (op == OP_REGIO) && !i;
    assign is_io      = (op == OP_REGIO) && i;
    assign need_indir = is_mem && i;

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode sequencer: fetches from RAM, resolves indirection and offers one
// decoded instruction at a time to execute over a valid/ready handshake.
module fetch_decode_unit
    import fetch_decode_unit_pkg::*;
#(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    fetch_decode_unit_if.master bus,
    input  logic                pc_load,
    input  logic [ADDR_W-1:0]   pc_value,
    input  logic                halt,
    input  logic                run,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted
);

    state_t            state;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ar;

    logic [2:0]        cls_op;
    logic              cls_i;
    logic [ADDR_W-1:0] cls_addr;
    logic              cls_mem;
    logic              cls_reg;
    logic              cls_io;
    logic              cls_indir;

    fetch_decode_unit_instr_classifier #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_classifier (
        .ir        (ir),
        .op        (cls_op),
        .i         (cls_i),
        .addr      (cls_addr),
        .is_mem    (cls_mem),
        .is_reg    (cls_reg),
        .is_io     (cls_io),
        .need_indir(cls_indir)
    );

    assign bus.dec_ea = ar;

    // All outputs are registered: mem_read/mem_addr are set on entry to FETCH/INDIR
    // and the dec_* group on entry to ISSUE, then cleared when leaving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_ADDR;
            pc             <= RESET_PC;
            ir             <= '0;
            ar             <= '0;
            halted         <= 1'b0;
            bus.mem_read   <= 1'b0;
            bus.mem_addr   <= '0;
            bus.dec_valid  <= 1'b0;
            bus.dec_ir     <= '0;
            bus.dec_op     <= '0;
            bus.dec_i      <= 1'b0;
            bus.dec_is_mem <= 1'b0;
            bus.dec_is_reg <= 1'b0;
            bus.dec_is_io  <= 1'b0;
        end else begin
            bus.mem_read <= 1'b0;
            bus.mem_addr <= '0;
            if (pc_load && state != S_HALT) begin
                pc             <= pc_value;
                state          <= S_ADDR;
                bus.dec_valid  <= 1'b0;
                bus.dec_ir     <= '0;
                bus.dec_op     <= '0;
                bus.dec_i      <= 1'b0;
                bus.dec_is_mem <= 1'b0;
                bus.dec_is_reg <= 1'b0;
                bus.dec_is_io  <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: begin
                        if (halt) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            state        <= S_FETCH;
                            bus.mem_read <= 1'b1;
                            bus.mem_addr <= pc;
                        end
                    end
                    S_FETCH: begin
                        ir    <= bus.mem_rdata;
                        pc    <= pc + ADDR_W'(1);
                        state <= S_DECODE;
                    end
                    S_DECODE: begin
                        ar             <= cls_addr;
                        bus.dec_ir     <= ir;
                        bus.dec_op     <= cls_op;
                        bus.dec_i      <= cls_i;
                        if (cls_indir) begin
                            state        <= S_INDIR;
                            bus.mem_read <= 1'b1;
                            bus.mem_addr <= cls_addr;
                        end else begin
                            state          <= S_ISSUE;
                            bus.dec_valid  <= 1'b1;
                            bus.dec_is_mem <= cls_mem;
                            bus.dec_is_reg <= cls_reg;
                            bus.dec_is_io  <= cls_io;
                        end
                    end
                    S_INDIR: begin
                        ar             <= bus.mem_rdata[ADDR_W-1:0];
                        state          <= S_ISSUE;
                        bus.dec_valid  <= 1'b1;
                        bus.dec_is_mem <= cls_mem;
                        bus.dec_is_reg <= cls_reg;
                        bus.dec_is_io  <= cls_io;
                    end
                    S_ISSUE: begin
                        if (bus.dec_ready) begin
                            state          <= S_ADDR;
                            bus.dec_valid  <= 1'b0;
                            bus.dec_ir     <= '0;
                            bus.dec_op     <= '0;
                            bus.dec_i      <= 1'b0;
                            bus.dec_is_mem <= 1'b0;
                            bus.dec_is_reg <= 1'b0;
                            bus.dec_is_io  <= 1'b0;
                        end
                    end
                    S_HALT: begin
                        if (pc_load) begin
                            pc <= pc_value;
                        end
                        if (run) begin
                            state  <= S_ADDR;
                            halted <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_ADDR;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit: table of single-instruction fetches plus
// hand-written sequences for redirect, backpressure, halt and mid-flight reset.
module tb_fetch_decode_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       pc_load;
    logic [3:0] pc_value;
    logic       halt;
    logic       run;
    logic [3:0] pc;
    logic       halted;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [16];

    fetch_decode_unit_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    assign bus.mem_rdata = ram[bus.mem_addr];

    fetch_decode_unit #(
        .ADDR_W  (4),
        .DATA_W  (8),
        .RESET_PC(4'd0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .pc_load (pc_load),
        .pc_value(pc_value),
        .halt    (halt),
        .run     (run),
        .pc      (pc),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    // One record per single-instruction fetch; cls is {mem, reg, io}.
    typedef struct {
        logic [3:0] addr;
        logic [7:0] ir;
        logic [2:0] op;
        logic       i;
        logic [3:0] ea;
        logic [2:0] cls;
        int         lat;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        pc_load       = 1'b0;
        pc_value      = 4'd0;
        halt          = 1'b0;
        run           = 1'b0;
        bus.dec_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_issue(input string tag, input vec_t v);
        check_output({tag, " dec_valid"}, 32'(bus.dec_valid), 32'd1);
        check_output({tag, " dec_ir"},    32'(bus.dec_ir),    32'(v.ir));
        check_output({tag, " dec_op"},    32'(bus.dec_op),    32'(v.op));
        check_output({tag, " dec_i"},     32'(bus.dec_i),     32'(v.i));
        check_output({tag, " dec_ea"},    32'(bus.dec_ea),    32'(v.ea));
        check_output({tag, " class"},
                     32'({bus.dec_is_mem, bus.dec_is_reg, bus.dec_is_io}), 32'(v.cls));
    endtask

    task automatic apply_stimulus(input vec_t v);
        int   cycles;
        logic [3:0] next_pc;
        string tag;
        tag = $sformatf("vec@%0h", v.addr);
        next_pc = v.addr + 4'd1;
        do_reset();
        pc_load  = 1'b1;
        pc_value = v.addr;
        tick();
        pc_load = 1'b0;
        check_output({tag, " pc after load"}, 32'(pc), 32'(v.addr));
        cycles = 0;
        while (!bus.dec_valid && cycles < 10) begin
            tick();
            cycles++;
        end
        check_output({tag, " latency"}, 32'(cycles), 32'(v.lat));
        check_issue(tag, v);
        check_output({tag, " pc"}, 32'(pc), 32'(next_pc));
        tick();
        check_output({tag, " accepted"}, 32'(bus.dec_valid), 32'd0);
    endtask

    initial begin
        vec_t v;
        for (int k = 0; k < 16; k++) ram[k] = 8'h00;
        ram[0]  = 8'h0C;
        ram[1]  = 8'h91;
        ram[2]  = 8'h26;
        ram[3]  = 8'h76;
        ram[4]  = 8'hA3;
        ram[5]  = 8'hF0;
        ram[6]  = 8'hC8;
        ram[8]  = 8'h3D;
        ram[10] = 8'h1B;
        ram[15] = 8'h05;

        vecs[0] = '{4'h0, 8'h0C, 3'd0, 1'b0, 4'hC, 3'b100, 3};
        vecs[1] = '{4'h1, 8'h91, 3'd1, 1'b1, 4'h1, 3'b100, 4};
        vecs[2] = '{4'h2, 8'h26, 3'd2, 1'b0, 4'h6, 3'b100, 3};
        vecs[3] = '{4'h3, 8'h76, 3'd7, 1'b0, 4'h6, 3'b010, 3};
        vecs[4] = '{4'h4, 8'hA3, 3'd2, 1'b1, 4'h6, 3'b100, 4};
        vecs[5] = '{4'h5, 8'hF0, 3'd7, 1'b1, 4'h0, 3'b001, 3};
        vecs[6] = '{4'h6, 8'hC8, 3'd4, 1'b1, 4'hD, 3'b100, 4};
        vecs[7] = '{4'hA, 8'h1B, 3'd1, 1'b0, 4'hB, 3'b100, 3};
        vecs[8] = '{4'hF, 8'h05, 3'd0, 1'b0, 4'h5, 3'b100, 3};

        // Reset values and the natural sequence from PC=0, including one indirect.
        rst = 1'b1; pc_load = 1'b0; pc_value = 4'd0; halt = 1'b0; run = 1'b0;
        bus.dec_ready = 1'b1;
        #2;
        check_output("reset dec_valid", 32'(bus.dec_valid), 32'd0);
        check_output("reset mem_read",  32'(bus.mem_read),  32'd0);
        check_output("reset halted",    32'(halted),        32'd0);
        check_output("reset pc",        32'(pc),            32'd0);
        check_output("reset dec_ir",    32'(bus.dec_ir),    32'd0);
        check_output("reset class",
                     32'({bus.dec_is_mem, bus.dec_is_reg, bus.dec_is_io}), 32'd0);
        tick();
        rst = 1'b0;
        check_output("t1 addr mem_read", 32'(bus.mem_read), 32'd0);
        tick();
        check_output("t1 fetch mem_read", 32'(bus.mem_read), 32'd1);
        check_output("t1 fetch mem_addr", 32'(bus.mem_addr), 32'd0);
        tick();
        check_output("t1 decode mem_read", 32'(bus.mem_read), 32'd0);
        check_output("t1 decode valid", 32'(bus.dec_valid), 32'd0);
        check_output("t1 decode pc", 32'(pc), 32'd1);
        tick();
        check_issue("t1", vecs[0]);
        tick();
        tick();
        check_output("t2 fetch mem_addr", 32'(bus.mem_addr), 32'd1);
        tick();
        tick();
        check_output("t2 indir mem_read", 32'(bus.mem_read), 32'd1);
        check_output("t2 indir mem_addr", 32'(bus.mem_addr), 32'd1);
        check_output("t2 indir valid", 32'(bus.dec_valid), 32'd0);
        tick();
        check_issue("t2", vecs[1]);

        // Asynchronous reset in the middle of a fetch.
        tick();
        tick();
        check_output("mid fetch mem_read", 32'(bus.mem_read), 32'd1);
        rst = 1'b1;
        #1;
        check_output("mid reset mem_read", 32'(bus.mem_read), 32'd0);
        check_output("mid reset pc", 32'(pc), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        check_output("post reset mem_addr", 32'(bus.mem_addr), 32'd0);
        tick();
        tick();
        check_issue("post reset", vecs[0]);

        for (int n = 0; n < 9; n++) begin
            v = vecs[n];
            apply_stimulus(v);
        end

        // Redirect during DECODE squashes the in-flight instruction.
        do_reset();
        tick();
        tick();
        pc_load = 1'b1; pc_value = 4'hA;
        tick();
        pc_load = 1'b0;
        check_output("t4 squash valid", 32'(bus.dec_valid), 32'd0);
        check_output("t4 pc", 32'(pc), 32'hA);
        tick();
        check_output("t4 fetch mem_addr", 32'(bus.mem_addr), 32'hA);
        check_output("t4 fetch valid", 32'(bus.dec_valid), 32'd0);
        tick();
        tick();
        check_issue("t4", vecs[7]);

        // Backpressure holds ISSUE; then pc_load beats a same-cycle accept.
        do_reset();
        bus.dec_ready = 1'b0;
        tick(); tick(); tick();
        for (int h = 0; h < 5; h++) begin
            check_issue($sformatf("t5 hold%0d", h), vecs[0]);
            check_output("t5 hold mem_read", 32'(bus.mem_read), 32'd0);
            check_output("t5 hold pc", 32'(pc), 32'd1);
            tick();
        end
        bus.dec_ready = 1'b1;
        pc_load = 1'b1; pc_value = 4'h5;
        tick();
        pc_load = 1'b0;
        check_output("t5 accept valid", 32'(bus.dec_valid), 32'd0);
        check_output("t5 redirect pc", 32'(pc), 32'h5);
        tick();
        check_output("t5 next mem_read", 32'(bus.mem_read), 32'd1);
        check_output("t5 next mem_addr", 32'(bus.mem_addr), 32'h5);

        // Halt at the instruction boundary, redirect while halted, then resume.
        do_reset();
        halt = 1'b1;
        tick();
        check_output("t6 halted", 32'(halted), 32'd1);
        check_output("t6 halt mem_read", 32'(bus.mem_read), 32'd0);
        tick(); tick();
        check_output("t6 still halted", 32'(halted), 32'd1);
        check_output("t6 halt mem_read2", 32'(bus.mem_read), 32'd0);
        check_output("t6 halt pc", 32'(pc), 32'd0);
        pc_load = 1'b1; pc_value = 4'h2;
        tick();
        pc_load = 1'b0;
        check_output("t6 halt load pc", 32'(pc), 32'h2);
        check_output("t6 halt after load", 32'(halted), 32'd1);
        halt = 1'b0; run = 1'b1;
        tick();
        run = 1'b0;
        check_output("t6 resumed", 32'(halted), 32'd0);
        tick();
        check_output("t6 resume mem_addr", 32'(bus.mem_addr), 32'h2);
        check_output("t6 resume mem_read", 32'(bus.mem_read), 32'd1);
        tick();
        tick();
        check_issue("t6", vecs[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
